// File: rtl/psum_sum_node_if.sv
// Valid/ready packet channel used on both sides of the partial-sum node.
// The master drives data and valid, and the slave drives ready.
interface psum_sum_node_if #(
    parameter int DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/psum_sum_node.sv
// Partial-sum reduction node. It collects NUM_PE row partial sums per output
// pixel, emits one output-feature-map packet per completed pixel toward the
// memory node, and pulses done once every pixel of the map has gone out.
module psum_sum_node #(
    parameter int                DATA_WIDTH       = 18,
    parameter int                VALID_DATA_WIDTH = 8,
    parameter int                WIDTH            = 4,
    parameter int                NUM_PE           = 5,
    parameter int                NUM_OUT          = 9,
    parameter logic [WIDTH-1:0]  SELF_INDEX       = 4'd10,
    parameter logic [WIDTH-1:0]  MEM_INDEX        = 4'd11
) (
    input  logic                   clk,
    input  logic                   rst,
    psum_sum_node_if.slave         in_if,
    psum_sum_node_if.master        out_if,
    output logic                   done,
    output logic [7:0]             drop_count,
    output logic                   busy
);
    localparam int                CNT_W      = 3;
    localparam logic [1:0]        TYPE_PSUM  = 2'b10;
    localparam logic [1:0]        TYPE_OFMAP = 2'b11;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NUM_PE - 1);

    // Per-slot state and its next-state image
    logic [VALID_DATA_WIDTH-1:0] acc_r   [NUM_OUT];
    logic [VALID_DATA_WIDTH-1:0] acc_n_s [NUM_OUT];
    logic [CNT_W-1:0]            cnt_r   [NUM_OUT];
    logic [CNT_W-1:0]            cnt_n_s [NUM_OUT];
    logic [NUM_OUT-1:0]          emitted_r, emitted_n_s;

    // Registered outputs and their next-state values
    logic                  out_valid_r, out_valid_n_s;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_n_s;
    logic                  done_r, done_n_s;
    logic [7:0]            drop_count_r, drop_count_n_s;
    logic                  busy_r, busy_n_s;

    // Handshake and decoded packet fields
    logic                        in_ready_s, in_xfer_s, out_xfer_s;
    logic [WIDTH-1:0]            idx_s, dest_s;
    logic [1:0]                  type_s;
    logic [VALID_DATA_WIDTH-1:0] psum_s;
    logic [NUM_OUT-1:0]          sel_s;
    logic [VALID_DATA_WIDTH-1:0] sel_acc_s, sum_s;
    logic [CNT_W-1:0]            sel_cnt_s;
    logic                        accept_s, complete_s;

    // Input is refused while an output is pending, so there is never a
    // same-cycle input/output bypass.
    assign in_ready_s = !out_valid_r && !rst;
    assign in_xfer_s  = in_if.valid && in_ready_s;
    assign out_xfer_s = out_valid_r && out_if.ready;

    assign idx_s  = in_if.data[DATA_WIDTH-1 -: WIDTH];
    assign dest_s = in_if.data[VALID_DATA_WIDTH+2+WIDTH-1 : VALID_DATA_WIDTH+2];
    assign type_s = in_if.data[VALID_DATA_WIDTH+1 : VALID_DATA_WIDTH];
    assign psum_s = in_if.data[VALID_DATA_WIDTH-1:0];

    // Decode the addressed slot and gather its current accumulator and count
    always_comb begin
        sel_s     = '0;
        sel_acc_s = '0;
        sel_cnt_s = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (idx_s == WIDTH'(i)) begin
                sel_s[i]  = 1'b1;
                sel_acc_s = acc_r[i];
                sel_cnt_s = cnt_r[i];
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    // An index outside 0..NUM_OUT-1 selects no slot, so it fails the fresh-slot test
    assign accept_s   = in_xfer_s && (dest_s == SELF_INDEX) && (type_s == TYPE_PSUM)
                        && (|(sel_s & ~emitted_r));
    assign sum_s      = sel_acc_s + psum_s;
    assign complete_s = (sel_cnt_s == LAST_CNT);

    // Next-state logic: drain, accumulate/complete, or count a dropped packet
    always_comb begin
        acc_n_s        = acc_r;
        cnt_n_s        = cnt_r;
        emitted_n_s    = emitted_r;
        out_valid_n_s  = out_valid_r;
        out_data_n_s   = out_data_r;
        done_n_s       = 1'b0;
        drop_count_n_s = drop_count_r;
        if (out_xfer_s) begin
            out_valid_n_s = 1'b0;
            // The pending packet was the last pixel of the map
            if (&emitted_r) begin
                done_n_s    = 1'b1;
                emitted_n_s = '0;
            end else begin
                done_n_s = 1'b0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (sel_s[i] && complete_s) begin
                    acc_n_s[i]     = '0;
                    cnt_n_s[i]     = '0;
                    emitted_n_s[i] = 1'b1;
                end else if (sel_s[i]) begin
                    acc_n_s[i] = sum_s;
                    cnt_n_s[i] = cnt_r[i] + 3'd1;
                end else begin
                    acc_n_s[i] = acc_r[i];
                end
            end
            if (complete_s) begin
                out_valid_n_s = 1'b1;
                out_data_n_s  = {idx_s, MEM_INDEX, TYPE_OFMAP, sum_s};
            end else begin
                out_valid_n_s = out_valid_r;
            end
        end else if (in_xfer_s) begin
            if (drop_count_r != 8'hFF) begin
                drop_count_n_s = drop_count_r + 8'd1;
            end else begin
                drop_count_n_s = drop_count_r;
            end
        end else begin
            done_n_s = 1'b0;
        end
    end

    // Busy is derived from next state so that the registered flag lines up with the slots
    always_comb begin
        busy_n_s = out_valid_n_s;
        for (int i = 0; i < NUM_OUT; i++) begin
            busy_n_s = busy_n_s | (cnt_n_s[i] != '0);
        end
    end

    // State registers with synchronous reset that discards any partial map
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                acc_r[i] <= '0;
                cnt_r[i] <= '0;
            end
            emitted_r    <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            done_r       <= 1'b0;
            drop_count_r <= 8'd0;
            busy_r       <= 1'b0;
        end else begin
            acc_r        <= acc_n_s;
            cnt_r        <= cnt_n_s;
            emitted_r    <= emitted_n_s;
            out_valid_r  <= out_valid_n_s;
            out_data_r   <= out_data_n_s;
            done_r       <= done_n_s;
            drop_count_r <= drop_count_n_s;
            busy_r       <= busy_n_s;
        end
    end

    assign in_if.ready  = in_ready_s;
    assign out_if.valid = out_valid_r;
    assign out_if.data  = out_data_r;
    assign done         = done_r;
    assign drop_count   = drop_count_r;
    assign busy         = busy_r;
endmodule

// File: tb/tb_psum_sum_node.sv
// Directed bench for psum_sum_node: single pixel, wraparound, backpressure,
// rejects, a full map with done, and mid-map reset.
module tb_psum_sum_node;
    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [7:0] drop_count;
    logic       busy;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_ref = 0;
    logic [17:0] out_q[$];
    logic [17:0] held;

    psum_sum_node_if #(.DATA_WIDTH(18)) in_if ();
    psum_sum_node_if #(.DATA_WIDTH(18)) out_if ();

    psum_sum_node dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (in_if),
        .out_if     (out_if),
        .done       (done),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record accepted outputs and done pulses away from the active edge
    always @(negedge clk) begin
        if (out_if.valid && out_if.ready) out_q.push_back(out_if.data);
        if (done) done_cnt++;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] out_pkt(input logic [3:0] idx, input logic [7:0] s);
        return {idx, 4'd11, 2'b11, s};
    endfunction

    // Present one packet for one transfer cycle, waiting (bounded) for in_ready
    task automatic send_pkt(input logic [3:0] idx, input logic [3:0] dest,
                            input logic [1:0] typ, input logic [7:0] ps);
        int guard = 0;
        while (!in_if.ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check_eq("in_ready_wait", 32'd0, 32'd1);
        in_if.valid = 1'b1;
        in_if.data  = {idx, dest, typ, ps};
        tick();
        in_if.valid = 1'b0;
        in_if.data  = 18'd0;
    endtask

    initial begin
        rst          = 1'b1;
        in_if.valid  = 1'b0;
        in_if.data   = 18'd0;
        out_if.ready = 1'b1;
        #1;
        tick();
        tick();
        // Reset state
        check_eq("rst_in_ready", in_if.ready, 1'b0);
        check_eq("rst_out_valid", out_if.valid, 1'b0);
        check_eq("rst_out_data", out_if.data, 18'd0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_drop", drop_count, 8'd0);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("rdy_after_rst", in_if.ready, 1'b1);

        // Single pixel: 10+20+30+40+50 = 150 at idx0
        send_pkt(4'd0, 4'd10, 2'b10, 8'd10);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd20);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd30);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd40);
        check_eq("t1_no_early_valid", out_if.valid, 1'b0);
        check_eq("t1_busy_partial", busy, 1'b1);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd50);
        check_eq("t1_valid", out_if.valid, 1'b1);
        check_eq("t1_data", out_if.data, 18'h02F96);
        check_eq("t1_in_ready_low", in_if.ready, 1'b0);
        tick();
        check_eq("t1_valid_fall", out_if.valid, 1'b0);
        check_eq("t1_in_ready_back", in_if.ready, 1'b1);
        check_eq("t1_no_done", done, 1'b0);
        check_eq("t1_busy_idle", busy, 1'b0);

        // Wraparound: 5 x 100 = 500 mod 256 = 244 at idx3
        for (int k = 0; k < 5; k++) send_pkt(4'd3, 4'd10, 2'b10, 8'd100);
        check_eq("t2_valid", out_if.valid, 1'b1);
        check_eq("t2_data", out_if.data, 18'h0EFF4);
        check_eq("t2_drop", drop_count, 8'd0);
        tick();
        check_eq("t2_valid_fall", out_if.valid, 1'b0);

        // Backpressure on idx1: 1+2+3+4+5 = 15
        out_if.ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_pkt(4'd1, 4'd10, 2'b10, 8'(k));
        check_eq("t3_valid", out_if.valid, 1'b1);
        check_eq("t3_data", out_if.data, 18'h06F0F);
        check_eq("t3_in_ready", in_if.ready, 1'b0);
        held = out_if.data;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t3_hold_valid", out_if.valid, 1'b1);
            check_eq("t3_hold_data", out_if.data, held);
            check_eq("t3_hold_in_ready", in_if.ready, 1'b0);
        end
        out_if.ready = 1'b1;
        tick();
        check_eq("t3_drain_valid", out_if.valid, 1'b0);
        check_eq("t3_drain_in_ready", in_if.ready, 1'b1);

        // Rejects: wrong dest, wrong type, index out of range, already emitted
        send_pkt(4'd2, 4'd9, 2'b10, 8'd5);
        check_eq("t4_drop_dest", drop_count, 8'd1);
        send_pkt(4'd2, 4'd10, 2'b01, 8'd5);
        check_eq("t4_drop_type", drop_count, 8'd2);
        send_pkt(4'd12, 4'd10, 2'b10, 8'd5);
        check_eq("t4_drop_idx", drop_count, 8'd3);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd5);
        check_eq("t4_drop_emitted", drop_count, 8'd4);
        check_eq("t4_no_state", busy, 1'b0);
        check_eq("t4_no_out", out_if.valid, 1'b0);

        // Finish the current map (idx 0,1,3 already out): remaining slots sum 10
        out_q.delete();
        done_ref = done_cnt;
        for (int s = 0; s < 9; s++) begin
            if (s != 0 && s != 1 && s != 3) begin
                for (int k = 0; k < 5; k++) send_pkt(4'(s), 4'd10, 2'b10, 8'd2);
            end
        end
        tick();
        tick();
        check_eq("t5a_count", out_q.size(), 6);
        if (out_q.size() == 6) begin
            check_eq("t5a_out2", out_q[0], out_pkt(4'd2, 8'd10));
            check_eq("t5a_out8", out_q[5], out_pkt(4'd8, 8'd10));
        end
        check_eq("t5a_done", done_cnt, done_ref + 1);

        // Full map: 45 packets round-robin over 0..8, psum 1 each
        out_q.delete();
        done_ref = done_cnt;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < 9; s++) send_pkt(4'(s), 4'd10, 2'b10, 8'd1);
        end
        check_eq("t5_last_valid", out_if.valid, 1'b1);
        check_eq("t5_last_data", out_if.data, 18'h22F05);
        check_eq("t5_done_early", done, 1'b0);
        tick();
        check_eq("t5_done_pulse", done, 1'b1);
        check_eq("t5_valid_fall", out_if.valid, 1'b0);
        tick();
        check_eq("t5_done_single", done, 1'b0);
        check_eq("t5_count", out_q.size(), 9);
        if (out_q.size() == 9) begin
            for (int s = 0; s < 9; s++) check_eq("t5_out", out_q[s], out_pkt(4'(s), 8'd5));
        end
        check_eq("t5_done_cnt", done_cnt, done_ref + 1);
        check_eq("t5_drop_kept", drop_count, 8'd4);
        send_pkt(4'd0, 4'd10, 2'b10, 8'd9);
        check_eq("t5_new_map_drop", drop_count, 8'd4);
        check_eq("t5_new_map_busy", busy, 1'b1);

        // Reset mid-map: partials to idx2 are discarded
        for (int k = 0; k < 3; k++) send_pkt(4'd2, 4'd10, 2'b10, 8'd50);
        rst = 1'b1;
        #1;
        check_eq("t6_in_ready_rst", in_if.ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_drop", drop_count, 8'd0);
        check_eq("t6_out_valid", out_if.valid, 1'b0);
        check_eq("t6_in_ready", in_if.ready, 1'b1);
        for (int k = 0; k < 5; k++) send_pkt(4'd2, 4'd10, 2'b10, 8'd7);
        check_eq("t6_valid", out_if.valid, 1'b1);
        check_eq("t6_data", out_if.data, 18'h0AF23);
        tick();
        check_eq("t6_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
